ahb_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one AHB-lite slave-side address/data path between NM requesting masters in the interconnect.
- Produces a one-hot address-phase grant, which drives the HADDR/HTRANS/HWRITE/HSIZE mux. Also produces a one-hot data-phase select, the address grant delayed by one accepted transfer, which drives the HWDATA mux and the HRDATA/HRESP return routing.
- Grant changes only at transfer boundaries (HREADY high) and never inside a burst.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_rr_arbiter_rr_pick.sv | 46 ++++
 rtl/ahb_rr_arbiter.sv | 113 +++++++++++
 tb/tb_ahb_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-lite shared definitions: HTRANS encodings and a one-hot to index helper.
// Latency: none; this package holds only types and a pure function.
// Backpressure: not applicable.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    // Binary index of a one-hot vector of up to 8 bits.
    // An all-zero input returns 0.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// Round-robin winner selection: search req upward from last_idx+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   req      : per-master request vector
//   last_idx : index of the current owner (searched last, so lowest priority)
//   win_oh   : one-hot winner, all zero when no request is present
//   win_idx  : binary index of win_oh
//   win_vld  : at least one request is present
module rr_pick
    import ahb_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = 2
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last_idx,
    output logic [NM-1:0] win_oh,
    output logic [IW-1:0] win_idx,
    output logic          win_vld
);

    always_comb begin
        win_oh  = '0;
        win_vld = 1'b0;
        // Offsets 1..NM; offset NM lands back on the owner itself, so the
        // owner only wins when nobody else is asking.
        for (int k = 1; k <= NM; k++) begin
            int j;
            j = int'(last_idx) + k;
            // Explicit wrap: last_idx < NM, so a single subtraction suffices
            // and non-power-of-two NM never yields an index >= NM.
            if (j >= NM) begin
                j = j - NM;
            end
            if (!win_vld && req[j]) begin
                win_oh[j] = 1'b1;
                win_vld   = 1'b1;
            end
        end
    end

    assign win_idx = IW'(oh2idx(8'(win_oh)));

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-lite arbiter: one-hot address grant plus data-phase owner.
// Latency: req -> addr_gnt one clock at the earliest; data_sel trails by one accepted transfer.
// Backpressure: hready low freezes all state; grant holds during SEQ/BUSY (and lock when ARB_LOCK_EN).
//
// Optional feature macro: ARB_LOCK_EN (HMASTLOCK support). Without it the
// lock input is ignored and locked is tied low.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-master HBUSREQ
//   lock       : per-master HMASTLOCK request
//   htrans     : HTRANS of the address-granted master (post-mux)
//   hready     : HREADY of the shared slave path
//   addr_gnt   : one-hot address-phase grant, addr_idx its index
//   data_sel   : one-hot data-phase owner, data_idx its index
//   data_vld   : current data phase carries a NONSEQ/SEQ transfer
//   locked     : lock currently held
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int NM    = 4,
    parameter int IW    = 2,
    parameter int DEF_M = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] lock,
    input  logic [1:0]    htrans,
    input  logic          hready,
    output logic [NM-1:0] addr_gnt,
    output logic [IW-1:0] addr_idx,
    output logic [NM-1:0] data_sel,
    output logic [IW-1:0] data_idx,
    output logic          data_vld,
    output logic          locked
);

    localparam logic [NM-1:0] DEF_OH  = {{(NM-1){1'b0}}, 1'b1} << DEF_M;
    localparam logic [IW-1:0] DEF_IDX = IW'(DEF_M);

    logic [NM-1:0] win_oh;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          in_burst;
    logic          hold;

    rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req      (req),
        .last_idx (addr_idx),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    assign in_burst = (htrans == HT_SEQ) || (htrans == HT_BUSY);

`ifdef ARB_LOCK_EN
    logic lock_nxt;

    // Lock is taken on the owner's NONSEQ with its lock bit set and kept
    // while that bit stays high. Holding on lock_nxt rather than the
    // registered flag keeps the grant on the very edge the lock is taken,
    // and releases it on the edge the owner drops its lock bit.
    assign lock_nxt = lock[addr_idx] && (locked || (htrans == HT_NONSEQ));
    assign hold     = in_burst || lock_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (hready) begin
            locked <= lock_nxt;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = &{1'b0, lock};
    assign hold        = in_burst;
    assign locked      = 1'b0;
`endif

    // Address grant: moves only on an accepted transfer boundary outside a
    // burst; with no requests the current owner stays parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_gnt <= DEF_OH;
            addr_idx <= DEF_IDX;
        end else if (hready && !hold && win_vld) begin
            addr_gnt <= win_oh;
            addr_idx <= win_idx;
        end
    end

    // Data phase follows the address phase by one accepted transfer. It
    // samples the pre-edge grant, so a same-edge grant switch hands over
    // ownership back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sel <= DEF_OH;
            data_idx <= DEF_IDX;
            data_vld <= 1'b0;
        end else if (hready) begin
            data_sel <= addr_gnt;
            data_idx <= addr_idx;
            data_vld <= htrans[1];
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;
    localparam int NM = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] req;
    logic [NM-1:0] lock;
    logic [1:0]    htrans;
    logic          hready;
    logic [NM-1:0] addr_gnt;
    logic [IW-1:0] addr_idx;
    logic [NM-1:0] data_sel;
    logic [IW-1:0] data_idx;
    logic          data_vld;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    ahb_rr_arbiter #(.NM(NM), .IW(IW), .DEF_M(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .htrans   (htrans),
        .hready   (hready),
        .addr_gnt (addr_gnt),
        .addr_idx (addr_idx),
        .data_sel (data_sel),
        .data_idx (data_idx),
        .data_vld (data_vld),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Owner after an accepted boundary = requester at the smallest forward
    // distance (1..NM) from the current owner, distance NM being the owner.
    int m_own, m_down, m_dvld, m_lock;

    function automatic int pick(input int own, input logic [NM-1:0] r);
        int best, bestd, d;
        best  = own;
        bestd = NM + 1;
        for (int i = 0; i < NM; i++) begin
            if (r[i]) begin
                d = (i - own + NM) % NM;
                if (d == 0) d = NM;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  ln;
        bit  hold;
        if (!rst_n) begin
            m_own = 0; m_down = 0; m_dvld = 0; m_lock = 0;
        end else if (hready) begin
            ln = 0;
`ifdef ARB_LOCK_EN
            ln = (lock[m_own] && (m_lock != 0 || htrans == 2'b10)) ? 1 : 0;
`endif
            hold   = (htrans == 2'b11) || (htrans == 2'b01) || (ln != 0);
            m_down = m_own;
            m_dvld = htrans[1];
            m_lock = ln;
            if (!hold) m_own = pick(m_own, req);
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NM-1:0] oh;
        oh = 4'(1) << m_own;
        cmp("model_addr_gnt", int'(addr_gnt), int'(oh));
        cmp("model_addr_idx", int'(addr_idx), m_own);
        oh = 4'(1) << m_down;
        cmp("model_data_sel", int'(data_sel), int'(oh));
        cmp("model_data_idx", int'(data_idx), m_down);
        cmp("model_data_vld", int'(data_vld), m_dvld);
        cmp("model_locked",   int'(locked),   m_lock);
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge: drive inputs, pass one posedge, return at the
    // following negedge.
    task automatic step(input logic [NM-1:0] r, input logic [1:0] t, input logic h);
        req = r; htrans = t; hready = h;
        @(negedge clk);
    endtask

    int exp_a [4] = '{2, 3, 0, 1};
    int exp_d [4] = '{1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; req = 4'b1111; lock = '0; htrans = 2'b00; hready = 1'b1;
        repeat (2) @(negedge clk);
        cmp("rst_addr_gnt", int'(addr_gnt), 1);
        cmp("rst_data_vld", int'(data_vld), 0);
        cmp("rst_data_sel", int'(data_sel), 1);
        rst_n = 1'b1;

        // First edge after release, IDLE: round-robin from master 0 -> 1.
        step(4'b1111, 2'b00, 1'b1);
        cmp("first_gnt", int'(addr_gnt), 2);

        // Rotation with NONSEQ every cycle.
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 2'b10, 1'b1);
            cmp("rot_addr_idx", int'(addr_idx), exp_a[i]);
            cmp("rot_data_idx", int'(data_idx), exp_d[i]);
            cmp("rot_data_vld", int'(data_vld), 1);
        end

        // Owner is 1; one more NONSEQ grants master 2, then its burst holds.
        step(4'b1111, 2'b10, 1'b1);
        cmp("burst_start", int'(addr_idx), 2);
        step(4'b1111, 2'b11, 1'b1);
        cmp("burst_seq", int'(addr_idx), 2);
        step(4'b1111, 2'b01, 1'b1);
        cmp("burst_busy", int'(addr_idx), 2);
        cmp("busy_data_vld", int'(data_vld), 0);
        step(4'b1111, 2'b11, 1'b1);
        cmp("burst_seq2", int'(addr_idx), 2);
        cmp("burst_data_idx", int'(data_idx), 2);
        step(4'b1111, 2'b00, 1'b1);
        cmp("burst_end", int'(addr_idx), 3);

        // Stall: hready low while req/htrans change.
        step(4'b0001, 2'b10, 1'b0);
        step(4'b0110, 2'b00, 1'b0);
        step(4'b1111, 2'b11, 1'b0);
        step(4'b0000, 2'b10, 1'b0);
        step(4'b0101, 2'b10, 1'b0);
        cmp("stall_addr_idx", int'(addr_idx), 3);
        cmp("stall_data_idx", int'(data_idx), 2);
        cmp("stall_data_vld", int'(data_vld), 0);
        step(4'b0001, 2'b10, 1'b1);
        cmp("stall_resume", int'(addr_idx), 0);

        // Sole requester is the owner: it keeps the grant.
        step(4'b0001, 2'b10, 1'b1);
        cmp("sole_owner", int'(addr_idx), 0);

        // Park: go to 3, drop all requests, then master 0 alone.
        step(4'b1000, 2'b00, 1'b1);
        cmp("to_three", int'(addr_idx), 3);
        step(4'b0000, 2'b00, 1'b1);
        step(4'b0000, 2'b00, 1'b1);
        cmp("park_idx", int'(addr_idx), 3);
        cmp("park_data_vld", int'(data_vld), 0);
        step(4'b0001, 2'b00, 1'b1);
        cmp("park_wake", int'(addr_idx), 0);

        // Wrap past the owner: owner 0, requesters 0 and 3 -> 3.
        step(4'b1001, 2'b10, 1'b1);
        cmp("wrap_pick", int'(addr_idx), 3);

        // Reset mid-burst: outputs return immediately.
        step(4'b1111, 2'b10, 1'b1);
        req = 4'b1111; htrans = 2'b11;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        cmp("midrst_gnt", int'(addr_gnt), 1);
        cmp("midrst_dvld", int'(data_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100, 2'b00, 1'b1);
        cmp("post_rst", int'(addr_idx), 2);

`ifdef ARB_LOCK_EN
        // Lock: get to master 1, lock it, IDLE holds, release moves to 2.
        step(4'b0010, 2'b00, 1'b1);
        cmp("lk_owner", int'(addr_idx), 1);
        lock = 4'b0010;
        step(4'b1111, 2'b10, 1'b1);
        cmp("lk_set", int'(locked), 1);
        cmp("lk_hold1", int'(addr_idx), 1);
        step(4'b1111, 2'b00, 1'b1);
        cmp("lk_hold2", int'(addr_idx), 1);
        lock = 4'b0000;
        step(4'b1111, 2'b00, 1'b1);
        cmp("lk_clear", int'(locked), 0);
        cmp("lk_move", int'(addr_idx), 2);
`else
        lock = 4'b1111;
        step(4'b1111, 2'b10, 1'b1);
        cmp("nolock_locked", int'(locked), 0);
        cmp("nolock_move", int'(addr_idx), 3);
`endif

        step(4'b0000, 2'b00, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
